// File: rtl/axi_memory_slave_burst.sv
// ---------------------------------------------------------------------------
// axi_memory_slave_burst
//
// AXI4 burst memory slave backed by a MEM_WORDS x DATA_WIDTH array. The write
// channel (AW/W/B) and the read channel (AR/R) each have their own FSM, and
// the two run concurrently.
//
// Supported bursts: FIXED and INCR. WRAP bursts are supported only when the
// macro AXI_SLAVE_WRAP_EN is defined. Without it, a WRAP burst is an error
// burst: writes are dropped with bresp=SLVERR, and reads return zero data
// with rresp=SLVERR.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   awid/awaddr/awlen/awsize/awburst write address channel (awvalid/awready)
//   wdata/wstrb/wlast                write data channel (wvalid/wready)
//   bid/bresp                        write response channel (bvalid/bready)
//   arid/araddr/arlen/arsize/arburst read address channel (arvalid/arready)
//   rid/rdata/rresp/rlast            read data channel (rvalid/rready)
// ---------------------------------------------------------------------------
module axi_memory_slave_burst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam logic [2:0]            MAX_SIZE  = 3'(OFFS);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS);

`ifdef AXI_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    // A beat is serviceable only if it lands inside the array and the burst
    // parameters are ones this slave implements.
    function automatic logic beatOk(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [2:0]            size,
                                    input logic [1:0]            burst);
        beatOk = ((addr >> OFFS) < MEM_LIMIT) && (size <= MAX_SIZE) &&
                 (burst != 2'b11) && (WRAP_EN || (burst != 2'b10));
    endfunction

    // Address of the following beat. A WRAP window is (len+1) << size bytes;
    // the upper bits stay fixed and only the in-window bits advance.
    function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0]            len,
                                                       input logic [2:0]            size,
                                                       input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrapMask;
        step     = ADDR_WIDTH'(1) << size;
        wrapMask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   nextAddr = addr;
            2'b10:   nextAddr = WRAP_EN ? ((addr & ~wrapMask) | ((addr + step) & wrapMask))
                                        : (addr + step);
            default: nextAddr = addr + step;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // ------------------------------------------------------------------ write
    wstate_e               wstate_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ID_WIDTH-1:0]   bid_q, wid_q;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic                  werr_q;
    logic                  wBeatOk, wLastBeat, wBeatErr, memWe;

    always_comb begin
        wBeatOk   = beatOk(waddr_q, wsize_q, wburst_q);
        wLastBeat = (wcnt_q == wlen_q);
        // A misplaced wlast taints the response but does not stop the write.
        wBeatErr  = !wBeatOk || (wlast != wLastBeat);
        memWe     = (wstate_q == W_DATA) && wvalid && wBeatOk;
        waddr_d   = nextAddr(waddr_q, wlen_q, wsize_q, wburst_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (awvalid) begin
                        wid_q     <= awid;
                        waddr_q   <= awaddr;
                        wlen_q    <= awlen;
                        wsize_q   <= awsize;
                        wburst_q  <= awburst;
                        wcnt_q    <= '0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        waddr_q <= waddr_d;
                        wcnt_q  <= wcnt_q + 8'd1;
                        if (wLastBeat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= wid_q;
                            bresp_q  <= (werr_q || wBeatErr) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end else begin
                            werr_q <= werr_q | wBeatErr;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Storage is intentionally not reset so contents survive resetn.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr_q[OFFS +: MEM_AW]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    rstate_e               rstate_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [1:0]            rresp_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic [ADDR_WIDTH-1:0] fetchAddr;
    logic [2:0]            fetchSize;
    logic [1:0]            fetchBurst;
    logic                  fetchOk;
    logic [DATA_WIDTH-1:0] fetchData;

    // The beat to fetch is the first one of a new burst while idle, otherwise
    // the one after the beat currently presented. Reading the array here and
    // registering it means a same-cycle write is not yet visible.
    always_comb begin
        raddr_d = nextAddr(raddr_q, rlen_q, rsize_q, rburst_q);
        if (rstate_q == R_IDLE) begin
            fetchAddr  = araddr;
            fetchSize  = arsize;
            fetchBurst = arburst;
        end else begin
            fetchAddr  = raddr_d;
            fetchSize  = rsize_q;
            fetchBurst = rburst_q;
        end
        fetchOk   = beatOk(fetchAddr, fetchSize, fetchBurst);
        fetchData = fetchOk ? mem[fetchAddr[OFFS +: MEM_AW]] : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arvalid) begin
                        raddr_q   <= araddr;
                        rlen_q    <= arlen;
                        rsize_q   <= arsize;
                        rburst_q  <= arburst;
                        rid_q     <= arid;
                        rcnt_q    <= '0;
                        rdata_q   <= fetchData;
                        rresp_q   <= fetchOk ? RESP_OKAY : RESP_SLVERR;
                        rlast_q   <= (arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_d;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rdata_q <= fetchData;
                            rresp_q <= fetchOk ? RESP_OKAY : RESP_SLVERR;
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_memory_slave_burst.sv
// ---------------------------------------------------------------------------
// tb_axi_memory_slave_burst
//
// Table of write/read bursts with their expected B and R results, applied in
// order. Expected responses go into scoreboard queues as each burst is
// issued; monitors pop and compare on every B and R handshake. Hand-written
// sequences cover read back-pressure, a misplaced wlast with B back-pressure,
// and a reset in the middle of a write burst.
// ---------------------------------------------------------------------------
module tb_axi_memory_slave_burst;

    logic        clk;
    logic        resetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_memory_slave_burst #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_WORDS(1024)
    ) dut (
        .clk(clk), .resetn(resetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit              isWrite;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [3:0]      id;
        logic [3:0][31:0] data;
        logic [3:0]      strb;
        logic [1:0]      resp;
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int    vecCount   = 0;
    int    miscompares = 0;
    vec_t  vecs[16];

    function automatic vec_t mk(input bit w, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] id, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [3:0] strb,
                                input logic [1:0] resp);
        vec_t v;
        v.isWrite = w;
        v.addr    = addr;
        v.len     = len;
        v.size    = size;
        v.burst   = burst;
        v.id      = id;
        v.data    = {d3, d2, d1, d0};
        v.strb    = strb;
        v.resp    = resp;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Holds valid until the matching ready is seen just before a rising edge.
    task automatic waitReady(input string name, input int which);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            case (which)
                0:       done = awready;
                1:       done = wready;
                default: done = arready;
            endcase
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput({name, " handshake timeout"}, 64'd0, 64'd1);
    endtask

    task automatic driveW(input logic [31:0] d, input logic [3:0] s, input logic l);
        wdata  = d;
        wstrb  = s;
        wlast  = l;
        wvalid = 1'b1;
        waitReady("W", 1);
        wvalid = 1'b0;
    endtask

    task automatic driveAw(input vec_t v);
        awid    = v.id;
        awaddr  = v.addr;
        awlen   = v.len;
        awsize  = v.size;
        awburst = v.burst;
        awvalid = 1'b1;
        waitReady("AW", 0);
        awvalid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int c = 0; c < 200 && (rq.size() != 0 || bq.size() != 0); c++) @(posedge clk);
        checkOutput("scoreboard drained", 64'(rq.size() + bq.size()), 64'd0);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.isWrite) begin
            bexp_t be;
            be.id   = v.id;
            be.resp = v.resp;
            bq.push_back(be);
            driveAw(v);
            for (int i = 0; i <= int'(v.len); i++) driveW(v.data[i], v.strb, i == int'(v.len));
        end else begin
            for (int i = 0; i <= int'(v.len); i++) begin
                rexp_t re;
                re.id   = v.id;
                re.data = v.data[i];
                re.resp = v.resp;
                re.last = (i == int'(v.len));
                rq.push_back(re);
            end
            arid    = v.id;
            araddr  = v.addr;
            arlen   = v.len;
            arsize  = v.size;
            arburst = v.burst;
            arvalid = 1'b1;
            waitReady("AR", 2);
            arvalid = 1'b0;
        end
        waitDrain();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " {awready,arready,wready,bvalid,rvalid,rlast}"},
                    64'({awready, arready, wready, bvalid, rvalid, rlast}), 64'b110000);
        checkOutput({tag, " {bresp,rresp,bid,rid,rdata}"},
                    64'({bresp, rresp, bid, rid, rdata}), 64'd0);
    endtask

    // R and B monitors: ready and valid are stable at the falling edge, so a
    // handshake is known to occur on the following rising edge.
    always @(negedge clk) begin
        if (resetn && rvalid && rready) begin
            if (rq.size() == 0) begin
                vecCount++;
                miscompares++;
                $display("[TB] FAIL unexpected R beat: got rid 0x%0h rdata 0x%0h, expected none", rid, rdata);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                checkOutput("R beat {rid,rdata,rresp,rlast}",
                            64'({rid, rdata, rresp, rlast}), 64'({e.id, e.data, e.resp, e.last}));
            end
        end
        if (resetn && bvalid && bready) begin
            if (bq.size() == 0) begin
                vecCount++;
                miscompares++;
                $display("[TB] FAIL unexpected B response: got bid 0x%0h bresp %0d, expected none", bid, bresp);
            end else begin
                bexp_t e;
                e = bq.pop_front();
                checkOutput("B {bid,bresp}", 64'({bid, bresp}), 64'({e.id, e.resp}));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        vecs[0]  = mk(1, 32'h10, 8'd3, 3'd2, 2'b01, 4'h1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF, 2'b00);
        vecs[1]  = mk(0, 32'h10, 8'd3, 3'd2, 2'b01, 4'h2, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF, 2'b00);
        vecs[2]  = mk(1, 32'h20, 8'd2, 3'd2, 2'b00, 4'h3, 32'h1, 32'h2, 32'h3, 32'h0, 4'hF, 2'b00);
        vecs[3]  = mk(0, 32'h20, 8'd0, 3'd2, 2'b01, 4'h4, 32'h3, 32'h0, 32'h0, 32'h0, 4'hF, 2'b00);
        vecs[4]  = mk(1, 32'h40, 8'd0, 3'd2, 2'b01, 4'h5, 32'hFFFFFFFF, 0, 0, 0, 4'hF, 2'b00);
        vecs[5]  = mk(1, 32'h40, 8'd0, 3'd2, 2'b01, 4'h6, 32'h12345678, 0, 0, 0, 4'h3, 2'b00);
        vecs[6]  = mk(0, 32'h40, 8'd0, 3'd2, 2'b01, 4'h7, 32'hFFFF5678, 0, 0, 0, 4'hF, 2'b00);
        vecs[7]  = mk(1, 32'h1000, 8'd0, 3'd2, 2'b01, 4'h8, 32'hDEADBEEF, 0, 0, 0, 4'hF, 2'b10);
        vecs[8]  = mk(0, 32'h1000, 8'd0, 3'd2, 2'b01, 4'h9, 32'h0, 0, 0, 0, 4'hF, 2'b10);
        vecs[9]  = mk(1, 32'h30, 8'd3, 3'd2, 2'b01, 4'hA, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'hF, 2'b00);
`ifdef AXI_SLAVE_WRAP_EN
        vecs[10] = mk(1, 32'h38, 8'd3, 3'd2, 2'b10, 4'hB, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'hF, 2'b00);
        vecs[11] = mk(0, 32'h30, 8'd3, 3'd2, 2'b01, 4'hC, 32'hB2, 32'hB3, 32'hB0, 32'hB1, 4'hF, 2'b00);
        vecs[12] = mk(0, 32'h38, 8'd3, 3'd2, 2'b10, 4'hD, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'hF, 2'b00);
`else
        vecs[10] = mk(1, 32'h38, 8'd3, 3'd2, 2'b10, 4'hB, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'hF, 2'b10);
        vecs[11] = mk(0, 32'h30, 8'd3, 3'd2, 2'b01, 4'hC, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'hF, 2'b00);
        vecs[12] = mk(0, 32'h38, 8'd3, 3'd2, 2'b10, 4'hD, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF, 2'b10);
`endif
        vecs[13] = mk(1, 32'h50, 8'd0, 3'd2, 2'b11, 4'hE, 32'h55, 0, 0, 0, 4'hF, 2'b10);
        vecs[14] = mk(0, 32'h10, 8'd0, 3'd3, 2'b01, 4'hF, 32'h0, 0, 0, 0, 4'hF, 2'b10);
        vecs[15] = mk(0, 32'h10, 8'd1, 3'd2, 2'b00, 4'h1, 32'hA0, 32'hA0, 0, 0, 4'hF, 2'b00);

        resetn  = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b1;

        // Reset takes effect without a clock edge.
        #2 resetn = 1'b0;
        #1 checkResetState("reset");
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Read back-pressure: stall the second beat for three cycles.
        begin
            for (int i = 0; i < 4; i++) begin
                rexp_t re;
                re.id   = 4'h3;
                re.data = 32'hA0 + 32'(i);
                re.resp = 2'b00;
                re.last = (i == 3);
                rq.push_back(re);
            end
            arid = 4'h3; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
            arvalid = 1'b1;
            waitReady("AR", 2);
            arvalid = 1'b0;
            for (int c = 0; c < 20 && rq.size() != 3; c++) @(posedge clk);
            #1 rready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checkOutput("R stall hold {rvalid,rdata,rlast,rresp}",
                            64'({rvalid, rdata, rlast, rresp}), 64'({1'b1, 32'hA1, 1'b0, 2'b00}));
            end
            @(posedge clk);
            #1 rready = 1'b1;
            waitDrain();
        end

        // Early wlast gives SLVERR; B payload must hold while bready is low.
        begin
            bexp_t be;
            be.id   = 4'h5;
            be.resp = 2'b10;
            bq.push_back(be);
            bready = 1'b0;
            driveAw(mk(1, 32'h80, 8'd1, 3'd2, 2'b01, 4'h5, 0, 0, 0, 0, 4'hF, 2'b10));
            driveW(32'h11, 4'hF, 1'b1);
            driveW(32'h22, 4'hF, 1'b0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checkOutput("B stall hold {bvalid,bresp,bid}",
                            64'({bvalid, bresp, bid}), 64'({1'b1, 2'b10, 4'h5}));
            end
            @(posedge clk);
            #1 bready = 1'b1;
            waitDrain();
        end

        // Reset while the second beat of a write burst is being offered.
        begin
            driveAw(mk(1, 32'h60, 8'd3, 3'd2, 2'b01, 4'h6, 0, 0, 0, 0, 4'hF, 2'b00));
            driveW(32'h61, 4'hF, 1'b0);
            wdata = 32'h62; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            @(negedge clk);
            #1 resetn = 1'b0;
            #1 checkResetState("mid-burst reset");
            wvalid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1 resetn = 1'b1;
            @(posedge clk);
            #1 checkOutput("post-reset {awready,bvalid}", 64'({awready, bvalid}), 64'b10);
            applyStimulus(vecs[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
        $finish;
    end

endmodule
